// File: rtl/hex_q16_pkg.sv
// Shared Q16.16 constants, FSM states and saturation helper
// for the hex-to-screen conversion block.
package hex_q16_pkg;

    localparam logic signed [31:0] SQRT3       = 32'sd113512;
    localparam logic signed [31:0] SQRT3_DIV_2 = 32'sd56756;
    localparam logic signed [31:0] THREE_DIV_2 = 32'sd98304;
    localparam logic signed [31:0] HALF        = 32'sd32768;

    localparam logic signed [31:0] Q16_MAX = 32'sh7FFFFFFF;
    localparam logic signed [31:0] Q16_MIN = 32'sh80000000;

    // Width used for every intermediate sum/product before clamping.
    localparam int WIDE_W = 80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Clamp a wide signed value into the Q16.16 range.
    function automatic logic signed [31:0] sat_q16(
        input logic signed [WIDE_W-1:0] v
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = {{(WIDE_W-32){1'b0}}, Q16_MAX};
        lo = {{(WIDE_W-32){1'b1}}, Q16_MIN};
        if (v > hi) begin
            return Q16_MAX;
        end else if (v < lo) begin
            return Q16_MIN;
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/hex_to_screen_q16_mul.sv
// Combinational signed Q16.16 x Q16.16 multiply,
// rescaled by >>>16 and clamped to 32 bits.
module q16_mul_sat
    import hex_q16_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] y
);

    logic signed [63:0] prod;
    logic signed [63:0] shifted;

    assign prod    = 64'(a) * 64'(b);
    assign shifted = prod >>> 16;
    assign y       = sat_q16({{(WIDE_W-64){shifted[63]}}, shifted});

endmodule

// File: rtl/hex_to_screen_q16.sv
// Axial hex (q, r) to Q16.16 screen centre, optionally followed
// by the six pointy-top corners, streamed one vertex per handshake.
module hex_to_screen_q16
    import hex_q16_pkg::*;
#(
    parameter int COORD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [COORD_W-1:0]  hex_q,
    input  logic [COORD_W-1:0]  hex_r,
    input  logic [31:0]         hex_size_q16,
    input  logic [31:0]         origin_x_q16,
    input  logic [31:0]         origin_y_q16,
    input  logic                corners_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         screen_x,
    output logic [31:0]         screen_y,
    output logic [2:0]          vert_idx,
    output logic                vert_last
);

    state_t state;
    state_t next_state;

    logic signed [COORD_W-1:0] q_r;
    logic signed [COORD_W-1:0] r_r;
    logic signed [31:0]        size_r;
    logic signed [31:0]        org_x;
    logic signed [31:0]        org_y;
    logic                      corners_r;

    logic signed [31:0] centre_x;
    logic signed [31:0] centre_y;
    logic signed [31:0] off_xa;
    logic signed [31:0] off_ya;
    logic signed [31:0] off_yb;
    logic signed [31:0] mul_xa;
    logic signed [31:0] mul_ya;

    logic signed [WIDE_W-1:0] q_w;
    logic signed [WIDE_W-1:0] r_w;
    logic signed [WIDE_W-1:0] size_w;
    logic signed [WIDE_W-1:0] org_x_w;
    logic signed [WIDE_W-1:0] org_y_w;
    logic signed [WIDE_W-1:0] k_sqrt3;
    logic signed [WIDE_W-1:0] k_s3d2;
    logic signed [WIDE_W-1:0] k_3d2;
    logic signed [WIDE_W-1:0] lin_x;
    logic signed [WIDE_W-1:0] lin_y;
    logic signed [WIDE_W-1:0] sum_x;
    logic signed [WIDE_W-1:0] sum_y;

    logic signed [33:0] dx;
    logic signed [33:0] dy;
    logic signed [33:0] vx;
    logic signed [33:0] vy;

    logic accept;
    logic adv;

    assign accept = in_valid && in_ready;
    assign adv    = out_valid && out_ready;

    assign q_w     = {{(WIDE_W-COORD_W){q_r[COORD_W-1]}}, q_r};
    assign r_w     = {{(WIDE_W-COORD_W){r_r[COORD_W-1]}}, r_r};
    assign size_w  = {{(WIDE_W-32){size_r[31]}}, size_r};
    assign org_x_w = {{(WIDE_W-32){org_x[31]}}, org_x};
    assign org_y_w = {{(WIDE_W-32){org_y[31]}}, org_y};
    assign k_sqrt3 = {{(WIDE_W-32){1'b0}}, SQRT3};
    assign k_s3d2  = {{(WIDE_W-32){1'b0}}, SQRT3_DIV_2};
    assign k_3d2   = {{(WIDE_W-32){1'b0}}, THREE_DIV_2};

    // int * Q16.16 terms are already Q16.16; only the size product rescales.
    assign lin_x = q_w * k_sqrt3 + r_w * k_s3d2;
    assign lin_y = r_w * k_3d2;
    assign sum_x = ((size_w * lin_x) >>> 16) + org_x_w;
    assign sum_y = ((size_w * lin_y) >>> 16) + org_y_w;

    q16_mul_sat u_mul_xa (
        .a (size_r),
        .b (SQRT3_DIV_2),
        .y (mul_xa)
    );

    q16_mul_sat u_mul_ya (
        .a (size_r),
        .b (HALF),
        .y (mul_ya)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        vert_last  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                next_state = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                vert_last = corners_r ? (vert_idx == 3'd6)
                                      : (vert_idx == 3'd0);
                if (out_ready && vert_last) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, centre/offset registers and vertex counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r       <= '0;
            r_r       <= '0;
            size_r    <= '0;
            org_x     <= '0;
            org_y     <= '0;
            corners_r <= 1'b0;
            centre_x  <= '0;
            centre_y  <= '0;
            off_xa    <= '0;
            off_ya    <= '0;
            off_yb    <= '0;
            vert_idx  <= '0;
        end else begin
            if (accept) begin
                q_r       <= hex_q;
                r_r       <= hex_r;
                size_r    <= hex_size_q16;
                org_x     <= origin_x_q16;
                org_y     <= origin_y_q16;
                corners_r <= corners_en;
            end
            if (state == CALC) begin
                centre_x <= sat_q16(sum_x);
                centre_y <= sat_q16(sum_y);
                off_xa   <= mul_xa;
                off_ya   <= mul_ya;
                off_yb   <= size_r;
                vert_idx <= 3'd0;
            end else if (adv && !vert_last) begin
                vert_idx <= vert_idx + 3'd1;
            end
        end
    end

    // Corner offset for the current vertex (angles 30+60k degrees).
    always_comb begin
        dx = '0;
        dy = '0;
        unique case (vert_idx)
            3'd1: begin
                dx = 34'(off_xa);
                dy = 34'(off_ya);
            end
            3'd2: begin
                dy = 34'(off_yb);
            end
            3'd3: begin
                dx = -34'(off_xa);
                dy = 34'(off_ya);
            end
            3'd4: begin
                dx = -34'(off_xa);
                dy = -34'(off_ya);
            end
            3'd5: begin
                dy = -34'(off_yb);
            end
            3'd6: begin
                dx = 34'(off_xa);
                dy = -34'(off_ya);
            end
            default: begin
                dx = '0;
                dy = '0;
            end
        endcase
    end

    assign vx = 34'(centre_x) + dx;
    assign vy = 34'(centre_y) + dy;

    assign screen_x = sat_q16({{(WIDE_W-34){vx[33]}}, vx});
    assign screen_y = sat_q16({{(WIDE_W-34){vy[33]}}, vy});

endmodule

// File: tb/tb_hex_to_screen_q16.sv
// Scoreboard bench for hex_to_screen_q16: directed requests push
// expected vertices, a negedge monitor pops and compares.
module tb_hex_to_screen_q16;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  idx;
        logic        last;
    } vtx_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] hex_q = '0;
    logic [15:0] hex_r = '0;
    logic [31:0] hex_size_q16 = '0;
    logic [31:0] origin_x_q16 = '0;
    logic [31:0] origin_y_q16 = '0;
    logic        corners_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] screen_x;
    logic [31:0] screen_y;
    logic [2:0]  vert_idx;
    logic        vert_last;

    int   tests = 0;
    int   fails = 0;
    vtx_t exp_q[$];

    hex_to_screen_q16 #(.COORD_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .hex_q        (hex_q),
        .hex_r        (hex_r),
        .hex_size_q16 (hex_size_q16),
        .origin_x_q16 (origin_x_q16),
        .origin_y_q16 (origin_y_q16),
        .corners_en   (corners_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .screen_x     (screen_x),
        .screen_y     (screen_y),
        .vert_idx     (vert_idx),
        .vert_last    (vert_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return v[31:0];
    endfunction

    // Expected stream from a hand-computed centre and corner offsets.
    task automatic push_hex(input longint cx, input longint cy,
                            input longint ox, input longint oya,
                            input longint oyb, input bit ce);
        longint dx[7];
        longint dy[7];
        int     n;
        vtx_t   v;
        dx[0] = 0;    dy[0] = 0;
        dx[1] = ox;   dy[1] = oya;
        dx[2] = 0;    dy[2] = oyb;
        dx[3] = -ox;  dy[3] = oya;
        dx[4] = -ox;  dy[4] = -oya;
        dx[5] = 0;    dy[5] = -oyb;
        dx[6] = ox;   dy[6] = -oya;
        n = ce ? 7 : 1;
        for (int i = 0; i < n; i++) begin
            v.x    = sat(cx + dx[i]);
            v.y    = sat(cy + dy[i]);
            v.idx  = i[2:0];
            v.last = (i == n - 1);
            exp_q.push_back(v);
        end
    endtask

    // Returns at #1 after the accepting edge (DUT is then in CALC).
    task automatic send(input logic [15:0] q, input logic [15:0] r,
                        input logic [31:0] sz, input logic [31:0] ox,
                        input logic [31:0] oy, input logic ce);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", {63'b0, in_ready}, 64'd1);
        hex_q = q;
        hex_r = r;
        hex_size_q16 = sz;
        origin_x_q16 = ox;
        origin_y_q16 = oy;
        corners_en = ce;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        hex_q = 16'h5A5A;
        hex_r = 16'hA5A5;
        hex_size_q16 = 32'h1234_5678;
        origin_x_q16 = 32'h0BAD_F00D;
        origin_y_q16 = 32'hDEAD_0001;
        corners_en = ~ce;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_ready_after"}, {63'b0, in_ready}, 64'd1);
    endtask

    // Monitor: compares handshaked vertices and checks stall stability.
    initial begin
        bit   stalled;
        vtx_t held;
        vtx_t e;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 0;
            end else begin
                if (out_valid) begin
                    check("ready_while_emit", {63'b0, in_ready}, 64'd0);
                end
                if (stalled) begin
                    check("stall_valid", {63'b0, out_valid}, 64'd1);
                    check("stall_x", {32'b0, screen_x}, {32'b0, held.x});
                    check("stall_y", {32'b0, screen_y}, {32'b0, held.y});
                    check("stall_idx", {61'b0, vert_idx}, {61'b0, held.idx});
                    check("stall_last", {63'b0, vert_last}, {63'b0, held.last});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_vertex: got idx %0d x %0h y %0h, expected none",
                                 vert_idx, screen_x, screen_y);
                    end else begin
                        e = exp_q.pop_front();
                        check("vtx_x", {32'b0, screen_x}, {32'b0, e.x});
                        check("vtx_y", {32'b0, screen_y}, {32'b0, e.y});
                        check("vtx_idx", {61'b0, vert_idx}, {61'b0, e.idx});
                        check("vtx_last", {63'b0, vert_last}, {63'b0, e.last});
                    end
                end
                stalled = out_valid && !out_ready;
                held.x = screen_x;
                held.y = screen_y;
                held.idx = vert_idx;
                held.last = vert_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_x", {32'b0, screen_x}, 64'd0);
        check("rst_y", {32'b0, screen_y}, 64'd0);
        check("rst_idx", {61'b0, vert_idx}, 64'd0);
        check("rst_last", {63'b0, vert_last}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Centre only, with latency check.
        out_ready = 1'b1;
        push_hex(64'h1BB68, 0, 56756, 32768, 65536, 0);
        send(16'd1, 16'd0, 32'h0001_0000, 32'h0, 32'h0, 1'b0);
        check("lat_calc_valid", {63'b0, out_valid}, 64'd0);
        check("lat_calc_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        check("lat_emit_valid", {63'b0, out_valid}, 64'd1);
        wait_drain("t1");

        // Offset origin, negative q, long downstream stall.
        out_ready = 1'b0;
        push_hex(64'hACDC8, 64'h30000, 113512, 65536, 131072, 0);
        send(-16'sd2, 16'd1, 32'h0002_0000, 32'h0010_0000, 32'h0, 1'b0);
        repeat (15) begin
            @(posedge clk); #1;
        end
        check("hold_valid", {63'b0, out_valid}, 64'd1);
        check("hold_idx", {61'b0, vert_idx}, 64'd0);
        out_ready = 1'b1;
        wait_drain("t2");

        // Full 7-vertex stream.
        push_hex(0, 0, 56756, 32768, 65536, 1);
        send(16'd0, 16'd0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        wait_drain("t3");

        // Same stream with out_ready toggling every cycle.
        out_ready = 1'b0;
        push_hex(0, 0, 56756, 32768, 65536, 1);
        send(16'd0, 16'd0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            n++;
        end
        check("t4_drained", 64'(exp_q.size()), 64'd0);
        check("t4_ready_after", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Positive saturation, with corners clamping too.
        push_hex(64'sd2147483647, 64'sd2147483647, 64'sd1859723852,
                 64'sd1073709056, 64'sd2147418112, 1);
        send(16'h7FFF, 16'h7FFF, 32'h7FFF_0000, 32'h0, 32'h0, 1'b1);
        wait_drain("t5");

        // Negative saturation.
        push_hex(-64'sd2147483648, -64'sd2147483648, 0, 0, 0, 0);
        send(16'h8000, 16'h8000, 32'h7FFF_0000, 32'h0, 32'h0, 1'b0);
        wait_drain("t6");

        // Zero size: every vertex sits on the origin.
        push_hex(64'h12345678, -64'sd256, 0, 0, 0, 1);
        send(16'd7, -16'sd3, 32'h0, 32'h1234_5678, 32'hFFFF_FF00, 1'b1);
        wait_drain("t7");

        // Negative size passes through arithmetically.
        push_hex(-64'sd113512, 0, -64'sd56756, -64'sd32768, -64'sd65536, 1);
        send(16'd1, 16'd0, 32'hFFFF_0000, 32'h0, 32'h0, 1'b1);
        wait_drain("t8");

        // Reset while presenting vertex 3.
        push_hex(0, 0, 56756, 32768, 65536, 1);
        send(16'd0, 16'd0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        n = 0;
        while (!(out_valid && vert_idx == 3'd3) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_reached_idx3", {61'b0, vert_idx}, 64'd3);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'b0, in_ready}, 64'd1);
        check("mid_rst_idx", {61'b0, vert_idx}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("post_rst_idle", {63'b0, out_valid}, 64'd0);
        push_hex(64'h1BB68, 0, 56756, 32768, 65536, 0);
        send(16'd1, 16'd0, 32'h0001_0000, 32'h0, 32'h0, 1'b0);
        wait_drain("t9");

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_to_screen_q16.md
Name: hex_to_screen_q16

Overview:
- Inverse of the vertex shader's pixel-to-hex step: takes integer axial hex coordinates (q, r) and converts them to a Q16.16 screen-space hex centre.
- When enabled, also emits the six pointy-top corner vertices, giving the rasterizer a 1- or 7-vertex stream per hex.
- Sits between the hex tile scheduler (upstream valid/ready) and the triangle setup stage (downstream valid/ready).

Parameters:
- COORD_W, 16, width of signed integer axial q/r inputs.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  hex request valid.
- in_ready  out  1  block can accept a request.
- hex_q  in  COORD_W  signed axial q (integer).
- hex_r  in  COORD_W  signed axial r (integer).
- hex_size_q16  in  32  hex radius, Q16.16, treated as signed.
- origin_x_q16  in  32  screen origin x, Q16.16 signed.
- origin_y_q16  in  32  screen origin y, Q16.16 signed.
- corners_en  in  1  1 = emit centre plus 6 corners; 0 = centre only.
- out_valid  out  1  vertex valid.
- out_ready  in  1  downstream accepts vertex.
- screen_x  out  32  vertex x, Q16.16.
- screen_y  out  32  vertex y, Q16.16.
- vert_idx  out  3  0 = centre, 1..6 = corners.
- vert_last  out  1  final vertex of this hex.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, screen_x=0, screen_y=0, vert_idx=0, vert_last=0.
- FSM states IDLE, CALC, EMIT. Only one hex is in flight; requests never overlap.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch hex_q, hex_r, hex_size_q16, both origins and corners_en, then go to CALC.
- CALC (1 cycle):
  - in_ready=0.
  - Compute centre_x = origin_x + size*(SQRT3*q + SQRT3_DIV_2*r).
  - Compute centre_y = origin_y + size*(THREE_DIV_2*r).
  - Compute corner offsets ox_a = size*SQRT3_DIV_2, oy_a = size*HALF, oy_b = size (all Q16.16).
  - Go to EMIT with vert_idx=0.
- EMIT:
  - out_valid=1.
  - Outputs hold stable while out_valid && !out_ready.
  - On handshake, advance vert_idx. Leave for IDLE after the handshake of the last vertex; in_ready is 1 on the following cycle.
- Vertex order (pointy-top, angle 30+60k degrees): 1:(+ox_a,+oy_a) 2:(0,+oy_b) 3:(-ox_a,+oy_a) 4:(-ox_a,-oy_a) 5:(0,-oy_b) 6:(+ox_a,-oy_a), each added to the centre.
- vert_last = (vert_idx==6) if corners_en latched, else (vert_idx==0).
- Latency: accept at cycle t, first out_valid at t+2. Max throughput with corners_en=0 is 1 hex per 3 cycles.
- Arithmetic:
  - Constants: SQRT3=113512, SQRT3_DIV_2=56756, THREE_DIV_2=98304, HALF=32768.
  - int*Q16.16 gives Q16.16 as a full-width signed product (no shift).
  - Q16.16*Q16.16 gives a 64-bit signed product; result = product>>>16.
  - All intermediate sums are kept at full width. Every final output and offset saturates to [0x80000000, 0x7FFFFFFF]; it never wraps.
- Boundaries:
  - hex_size_q16=0 gives all 7 vertices equal to the origin.
  - Negative size is passed through arithmetically and is not flagged.
  - out_ready held low indefinitely leaves the FSM waiting in EMIT with no data change.
  - Input changes after acceptance are ignored.
  - Reset mid-EMIT returns the block to the reset state immediately; the partial vertex stream is dropped.

Decomposition:
- Package hex_q16_pkg holds:
  - the Q16.16 constants above (shared with vertex_shader_hex_q16 constants);
  - the state enum (IDLE/CALC/EMIT);
  - Q16_MAX/Q16_MIN.
- One sub-module: q16_mul_sat. It is combinational, does a signed Q16.16 x Q16.16 multiply with >>>16 and saturation to 32 bits, and is instanced for the size products.

Test Plan:
- size=0x00010000, origin 0, q=1, r=0, corners_en=0 -> one vertex at x=0x0001BB68, y=0, vert_idx=0, vert_last=1, out_valid 2 cycles after accept.
- size=0x00020000, origin=(0x00100000,0), q=-2, r=1 -> x=0x00100000-340536=0x000ACDC8, y=0x00030000.
- size=1.0, q=0, r=0, corners_en=1, out_ready=1 -> 7 consecutive vertices:
  - (0,0), (56756,32768), (0,65536), (-56756,32768), (-56756,-32768), (0,-65536), (56756,-32768);
  - vert_last only on idx 6;
  - in_ready=1 the cycle after.
- Same corner request with out_ready toggled 0/1 every cycle -> identical 7-vertex sequence, outputs stable during stalls, in_ready=0 throughout.
- size=0x7FFF0000, q=0x7FFF, r=0x7FFF -> screen_x=0x7FFFFFFF, screen_y=0x7FFFFFFF (saturated); same with q=r=-0x8000 -> 0x80000000.
- Assert reset while in EMIT at vert_idx=3 -> out_valid=0 and in_ready=1 immediately, with no further vertices; a new request afterwards behaves normally.
